ring_sequence_checker: RTL and testbench

- Receive-side monitor for the one-hot ring-counter pattern that user logic drives onto mprj_io pins.
- Samples a WIDTH-bit pin group from the IO pads and resynchronises it, then glitch-filters it.
- Checks that every accepted value is one-hot and is the correct ring successor of the previous value.
- Reports lock, sticky error and counters to user logic and Wishbone status.

---
 rtl/ring_sequence_checker.sv | 169 ++++++++++++++++
 tb/tb_ring_sequence_checker.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ring_sequence_checker.sv
// ring_sequence_checker
// Receive-side monitor for a one-hot ring-counter pattern on IO pins.
// The pins are resynchronised and glitch-filtered. Each accepted value is
// checked for being one-hot and for being the ring successor of the
// previously accepted value.
//
// Ports:
//   clock        system clock
//   resetb       asynchronous active-low reset
//   ring_in      raw pin inputs, asynchronous to clock
//   clear_i      synchronous pulse: clear the sticky error and restart the search
//   locked       high while the ring is locked
//   error        high while in the sticky error state
//   err_code     0 none, 1 not one-hot, 2 wrong successor, 3 stall timeout
//   trans_count  correct transitions since the last (re)start, saturating
//   err_count    error events since reset, saturating
//   last_value   most recently accepted value
module ring_sequence_checker #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned DIR        = 0,
  parameter int unsigned FILTER     = 2,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             clear_i,
  output logic             locked,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [15:0]      trans_count,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] last_value
);

  // The stability counter saturates at FILTER+1 so that it equals FILTER
  // for exactly one cycle per run.
  localparam int unsigned CNT_W = $clog2(FILTER + 2);
  // The timer never exceeds TIMEOUT-1 while it is counting.
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   s1, s2;
  logic [CNT_W-1:0]   stable_cnt;
  logic [TMR_W-1:0]   idle_timer, timer_nxt;
  logic [TMR_W:0]     timer_inc;
  logic               accept, tracking, timeout_hit, to_err;
  logic [1:0]         code_nxt;
  logic [15:0]        trans_nxt, trans_inc;
  logic [7:0]         errcnt_nxt;
  logic [WIDTH-1:0]   last_nxt;

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
  endfunction

  function automatic logic [WIDTH-1:0] succ(input logic [WIDTH-1:0] p);
    if (DIR != 0) return {p[WIDTH-2:0], p[WIDTH-1]};
    else          return {p[0], p[WIDTH-1:1]};
  endfunction

  // Two-flop synchroniser and run-length counter on the synchronised value.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      s1         <= '0;
      s2         <= '0;
      stable_cnt <= '0;
    end else begin
      s1 <= ring_in;
      s2 <= s1;
      if (s1 != s2)
        stable_cnt <= CNT_W'(1);
      else if (stable_cnt <= CNT_W'(FILTER))
        stable_cnt <= stable_cnt + CNT_W'(1);
    end
  end

  assign accept      = (stable_cnt == CNT_W'(FILTER)) && (s2 != last_value);
  assign tracking    = (state == ST_TRACK) || (state == ST_LOCKED);
  assign timer_inc   = (TMR_W+1)'(idle_timer) + (TMR_W+1)'(1);
  assign timeout_hit = (TIMEOUT != 0) && tracking && (timer_inc == (TMR_W+1)'(TIMEOUT));
  assign trans_inc   = (trans_count == 16'hFFFF) ? trans_count : trans_count + 16'd1;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt  = state;
    code_nxt   = err_code;
    trans_nxt  = trans_count;
    errcnt_nxt = err_count;
    last_nxt   = last_value;
    timer_nxt  = '0;
    to_err     = 1'b0;

    if (clear_i) begin
      state_nxt = ST_IDLE;
      code_nxt  = 2'd0;
      trans_nxt = '0;
    end else begin
      if (accept) last_nxt = s2;
      if ((TIMEOUT != 0) && tracking && !accept && !timeout_hit)
        timer_nxt = timer_inc[TMR_W-1:0];

      case (state)
        ST_IDLE: begin
          if (accept && is_onehot(s2)) begin
            state_nxt = ST_TRACK;
            trans_nxt = '0;
          end
        end
        ST_TRACK, ST_LOCKED: begin
          if (accept) begin
            if (!is_onehot(s2)) begin
              to_err   = 1'b1;
              code_nxt = 2'd1;
            end else if (s2 == succ(last_value)) begin
              trans_nxt = trans_inc;
              if (trans_inc >= 16'(LOCK_COUNT)) state_nxt = ST_LOCKED;
            end else begin
              to_err   = 1'b1;
              code_nxt = 2'd2;
            end
          end else if (timeout_hit) begin
            to_err   = 1'b1;
            code_nxt = 2'd3;
          end
        end
        ST_ERR: begin
        end
      endcase

      if (to_err) begin
        state_nxt  = ST_ERR;
        errcnt_nxt = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state       <= ST_IDLE;
      idle_timer  <= '0;
      locked      <= 1'b0;
      error       <= 1'b0;
      err_code    <= 2'd0;
      trans_count <= '0;
      err_count   <= '0;
      last_value  <= '0;
    end else begin
      state       <= state_nxt;
      idle_timer  <= timer_nxt;
      locked      <= (state_nxt == ST_LOCKED);
      error       <= (state_nxt == ST_ERR);
      err_code    <= code_nxt;
      trans_count <= trans_nxt;
      err_count   <= errcnt_nxt;
      last_value  <= last_nxt;
    end
  end

endmodule

// File: tb/tb_ring_sequence_checker.sv
// Testbench for ring_sequence_checker: table-driven vectors plus hand-written
// sequences for glitch rejection, asynchronous reset, and stall timeout.
module tb_ring_sequence_checker;

  logic        clock;
  logic        resetb;
  logic [3:0]  ring_in;
  logic        clear_i;
  logic        locked;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] trans_count;
  logic [7:0]  err_count;
  logic [3:0]  last_value;

  int tests = 0;
  int fails = 0;

  ring_sequence_checker #(
    .WIDTH(4), .DIR(0), .FILTER(2), .LOCK_COUNT(4), .TIMEOUT(50)
  ) dut (
    .clock      (clock),
    .resetb     (resetb),
    .ring_in    (ring_in),
    .clear_i    (clear_i),
    .locked     (locked),
    .error      (error),
    .err_code   (err_code),
    .trans_count(trans_count),
    .err_count  (err_count),
    .last_value (last_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  ring;
    int          hold;
    bit          clr;
    bit          e_locked;
    bit          e_error;
    logic [1:0]  e_code;
    logic [15:0] e_trans;
    logic [7:0]  e_errcnt;
    logic [3:0]  e_last;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] ring, input int hold, input bit clr,
                              input bit lk, input bit er, input logic [1:0] code,
                              input logic [15:0] tr, input logic [7:0] ec,
                              input logic [3:0] last);
    vec_t v;
    v.ring = ring; v.hold = hold; v.clr = clr;
    v.e_locked = lk; v.e_error = er; v.e_code = code;
    v.e_trans = tr; v.e_errcnt = ec; v.e_last = last;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit lk, input bit er, input logic [1:0] code,
                           input logic [15:0] tr, input logic [7:0] ec, input logic [3:0] last);
    check({tag, ".locked"},      32'(locked),      32'(lk));
    check({tag, ".error"},       32'(error),       32'(er));
    check({tag, ".err_code"},    32'(err_code),    32'(code));
    check({tag, ".trans_count"}, 32'(trans_count), 32'(tr));
    check({tag, ".err_count"},   32'(err_count),   32'(ec));
    check({tag, ".last_value"},  32'(last_value),  32'(last));
  endtask

  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ring_in = vecs[i].ring;
      for (int t = 0; t < vecs[i].hold; t++) begin
        clear_i = (t == 0) && vecs[i].clr;
        tick();
      end
      clear_i = 1'b0;
      check_all($sformatf("vec%0d", i), vecs[i].e_locked, vecs[i].e_error, vecs[i].e_code,
                vecs[i].e_trans, vecs[i].e_errcnt, vecs[i].e_last);
    end
  endtask

  initial begin
    int lat;
    int tmo;

    // ring, hold, clr | locked, error, code, trans, err_count, last
    vecs.push_back(mk(4'b0000,  5, 0, 0, 0, 0, 0, 0, 4'b0000)); // 0
    vecs.push_back(mk(4'b1000, 10, 0, 0, 0, 0, 0, 0, 4'b1000)); // 1 enter TRACK
    vecs.push_back(mk(4'b0100, 10, 0, 0, 0, 0, 1, 0, 4'b0100));
    vecs.push_back(mk(4'b0010, 10, 0, 0, 0, 0, 2, 0, 4'b0010));
    vecs.push_back(mk(4'b0001, 10, 0, 0, 0, 0, 3, 0, 4'b0001));
    vecs.push_back(mk(4'b1000, 10, 0, 1, 0, 0, 4, 0, 4'b1000)); // 5 lock
    vecs.push_back(mk(4'b0100, 10, 0, 1, 0, 0, 5, 0, 4'b0100));
    vecs.push_back(mk(4'b0001, 10, 0, 0, 1, 2, 5, 1, 4'b0001)); // 7 wrong successor
    vecs.push_back(mk(4'b0010, 10, 0, 0, 1, 2, 5, 1, 4'b0010)); // 8 still tracks last_value
    vecs.push_back(mk(4'b0010,  5, 1, 0, 0, 0, 0, 1, 4'b0010)); // 9 clear
    vecs.push_back(mk(4'b1000, 10, 0, 0, 0, 0, 0, 1, 4'b1000));
    vecs.push_back(mk(4'b0100, 10, 0, 0, 0, 0, 1, 1, 4'b0100));
    vecs.push_back(mk(4'b1100, 10, 0, 0, 1, 1, 1, 2, 4'b1100)); // 12 not one-hot
    vecs.push_back(mk(4'b1100,  5, 1, 0, 0, 0, 0, 2, 4'b1100)); // 13 clear
    vecs.push_back(mk(4'b0000, 10, 0, 0, 0, 0, 0, 2, 4'b0000)); // 14 zero tolerated in IDLE
    vecs.push_back(mk(4'b0011, 10, 0, 0, 0, 0, 0, 2, 4'b0011));
    vecs.push_back(mk(4'b1000, 10, 0, 0, 0, 0, 0, 2, 4'b1000));
    vecs.push_back(mk(4'b0100, 10, 0, 0, 0, 0, 1, 2, 4'b0100));
    vecs.push_back(mk(4'b0010, 10, 0, 0, 0, 0, 2, 2, 4'b0010));
    vecs.push_back(mk(4'b0001, 10, 0, 0, 0, 0, 3, 2, 4'b0001));
    vecs.push_back(mk(4'b1000, 10, 0, 1, 0, 0, 4, 2, 4'b1000)); // 20 relock
    vecs.push_back(mk(4'b0100, 10, 0, 1, 0, 0, 5, 2, 4'b0100));
    vecs.push_back(mk(4'b0010, 10, 0, 1, 0, 0, 6, 2, 4'b0010));
    vecs.push_back(mk(4'b0001, 10, 0, 1, 0, 0, 7, 2, 4'b0001)); // 23 trans_count 7
    // after asynchronous reset
    vecs.push_back(mk(4'b0000,  5, 0, 0, 0, 0, 0, 0, 4'b0000)); // 24
    vecs.push_back(mk(4'b1000, 10, 0, 0, 0, 0, 0, 0, 4'b1000)); // 25
    vecs.push_back(mk(4'b0100, 10, 0, 0, 0, 0, 1, 0, 4'b0100)); // 26
    vecs.push_back(mk(4'b0010, 10, 0, 0, 0, 0, 2, 0, 4'b0010));
    vecs.push_back(mk(4'b0001, 10, 0, 0, 0, 0, 3, 0, 4'b0001));
    vecs.push_back(mk(4'b1000, 10, 0, 1, 0, 0, 4, 0, 4'b1000)); // 29 locked

    resetb  = 1'b0;
    ring_in = 4'b0000;
    clear_i = 1'b0;
    #12;
    check_all("reset", 0, 0, 0, 0, 0, 4'b0000);
    resetb = 1'b1;
    tick();

    apply_range(0, 23);

    // Asynchronous reset while LOCKED with trans_count 7.
    #3;
    resetb = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0, 4'b0000);
    ring_in = 4'b0000;
    tick();
    tick();
    #4;
    resetb = 1'b1;
    tick();

    apply_range(24, 25);

    // One-cycle glitch during a 1000 hold is filtered out.
    ring_in = 4'b0010;
    tick();
    ring_in = 4'b1000;
    for (int t = 0; t < 10; t++) tick();
    check_all("glitch", 0, 0, 0, 0, 0, 4'b1000);

    apply_range(26, 29);

    // Acceptance latency, then stall timeout while LOCKED.
    ring_in = 4'b0100;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (last_value == 4'b0100) begin
        lat = k;
        break;
      end
    end
    check("accept_latency", 32'(lat), 32'd4);
    check("pre_timeout.locked", 32'(locked), 32'd1);
    check("pre_timeout.trans_count", 32'(trans_count), 32'd5);
    tmo = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (error) begin
        tmo = k;
        break;
      end
    end
    check("timeout_cycle", 32'(tmo), 32'd50);
    check_all("timeout", 0, 1, 3, 5, 1, 4'b0100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
